// File: rtl/inst_boot_rom_pkg.sv
// Shared encodings and constants for the boot-loading instruction store.
// The state codes are 3-bit constants so older tools that compare raw codes keep working.
package inst_boot_rom_pkg;

    localparam int BOOT_BYTE_W  = 8;
    localparam int BOOT_HDR_LEN = 2;

    localparam logic [2:0] BOOT_LEN_HI = 3'd0;
    localparam logic [2:0] BOOT_LEN_LO = 3'd1;
    localparam logic [2:0] BOOT_DATA   = 3'd2;
    localparam logic [2:0] BOOT_CHECK  = 3'd3;
    localparam logic [2:0] BOOT_RUN    = 3'd4;
    localparam logic [2:0] BOOT_ERROR  = 3'd5;

endpackage

// File: rtl/boot_ram.sv
// Instruction RAM: one synchronous write port, asynchronous read port.
// Contents are never cleared; reset has no effect here.
module boot_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_boot_rom.sv
// Boot-loaded instruction store: receives a framed byte image (count, payload, XOR),
// holds the core in reset until the image verifies, then serves combinational fetches.
module inst_boot_rom
    import inst_boot_rom_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BOOT_BYTE_W-1:0] in_data_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   rom_ce_i,
    input  logic [31:0]            rom_addr_i,
    output logic [31:0]            rom_data_o,
    output logic                   core_rst_o,
    output logic                   load_done_o,
    output logic                   load_err_o
);

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

    logic [2:0]             state;
    logic [BOOT_BYTE_W-1:0] cnt_hi;
    logic [15:0]            count;
    logic [15:0]            word_ptr;
    logic [15:0]            ptr_next;
    logic [15:0]            len_full;
    logic [1:0]             lane;
    logic [23:0]            asm_q;
    logic [BOOT_BYTE_W-1:0] xor_acc;

    logic                   accept;
    logic                   we;
    logic [31:0]            wdata;
    logic [31:0]            rdata;
    logic                   addr_in_range;
    logic                   addr_lo_unused;

    always_comb begin
        in_ready_o = 1'b0;
        if (!rst) begin
            in_ready_o = (state == BOOT_LEN_HI) || (state == BOOT_LEN_LO) ||
                         (state == BOOT_DATA)   || (state == BOOT_CHECK);
        end
    end

    assign accept   = in_valid_i && in_ready_o;
    assign len_full = {cnt_hi, in_data_i};
    assign ptr_next = word_ptr + 16'd1;
    assign we       = accept && (state == BOOT_DATA) && (lane == 2'd3);
    assign wdata    = {asm_q, in_data_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT_LEN_HI;
            cnt_hi      <= '0;
            count       <= '0;
            word_ptr    <= '0;
            lane        <= '0;
            xor_acc     <= '0;
            core_rst_o  <= 1'b1;
            load_done_o <= 1'b0;
            load_err_o  <= 1'b0;
        end else if (accept) begin
            case (state)
                BOOT_LEN_HI: begin
                    cnt_hi <= in_data_i;
                    state  <= BOOT_LEN_LO;
                end
                BOOT_LEN_LO: begin
                    count <= len_full;
                    if ({1'b0, len_full} > DEPTH) begin
                        state      <= BOOT_ERROR;
                        load_err_o <= 1'b1;
                    end else if (len_full == 16'd0) begin
                        state <= BOOT_CHECK;
                    end else begin
                        state <= BOOT_DATA;
                    end
                end
                BOOT_DATA: begin
                    xor_acc <= xor_acc ^ in_data_i;
                    if (lane == 2'd3) begin
                        lane     <= 2'd0;
                        word_ptr <= ptr_next;
                        if (ptr_next == count) begin
                            state <= BOOT_CHECK;
                        end
                    end else begin
                        lane <= lane + 2'd1;
                    end
                end
                BOOT_CHECK: begin
                    if (in_data_i == xor_acc) begin
                        state       <= BOOT_RUN;
                        core_rst_o  <= 1'b0;
                        load_done_o <= 1'b1;
                    end else begin
                        state      <= BOOT_ERROR;
                        load_err_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Big-endian assembly: earlier bytes shift toward the top of the word.
    always_ff @(posedge clk) begin
        if (accept && (state == BOOT_DATA) && (lane != 2'd3)) begin
            asm_q <= {asm_q[15:0], in_data_i};
        end
    end

    boot_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(word_ptr[ADDR_WIDTH-1:0]),
        .wdata(wdata),
        .raddr(rom_addr_i[ADDR_WIDTH+1:2]),
        .rdata(rdata)
    );

    // Byte offset within a word is irrelevant to word fetches.
    assign addr_lo_unused = ^rom_addr_i[1:0];
    assign addr_in_range  = (rom_addr_i[31:ADDR_WIDTH+2] == '0);
    assign rom_data_o     = (rom_ce_i && addr_in_range) ? rdata : 32'd0;

endmodule
